// File: rtl/ad_dac_pkg.sv
// Shared encodings and helpers for the DAC framer.
package ad_dac_pkg;

    localparam int unsigned PERIOD_W = 8;
    localparam int unsigned UNF_W    = 16;

    typedef enum logic [1:0] {
        SRC_DMA  = 2'd0,
        SRC_ZERO = 2'd1,
        SRC_RAMP = 2'd2,
        SRC_HOLD = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } dac_state_e;

    // A programmed frame length of zero behaves as a length of one.
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

endpackage

// File: rtl/ad_dac_framer_channel.sv
// One DAC channel: source mux, ramp generator, hold register and output format.
module ad_dac_framer_channel
    import ad_dac_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_CHANNEL = 4,
    parameter int unsigned DATA_WIDTH          = 16
) (
    input  logic                                      dac_clk,
    input  logic                                      dac_rstn,
    input  logic                                      run_active,
    input  logic                                      arm_entry,
    input  logic                                      frame_mark,
    input  logic                                      accept,
    input  logic                                      datafmt,
    input  logic                                      enable,
    input  logic [1:0]                                sel,
    input  logic [SAMPLES_PER_CHANNEL*DATA_WIDTH-1:0] ddata,
    output logic [SAMPLES_PER_CHANNEL*DATA_WIDTH-1:0] data,
    output logic [SAMPLES_PER_CHANNEL-1:0]            frame
);

    localparam int unsigned LANE_W = SAMPLES_PER_CHANNEL * DATA_WIDTH;

    src_sel_e                  sel_c;
    logic [LANE_W-1:0]         ramp_c, src_c, fmt_c;
    logic [LANE_W-1:0]         data_q, data_d, hold_q, hold_d;
    logic [SAMPLES_PER_CHANNEL-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0]     base_q, base_d;

    assign sel_c = src_sel_e'(sel);
    assign data  = data_q;
    assign frame = frame_q;

    // Select the source, apply enable and format, and advance ramp/hold state.
    always_comb begin
        ramp_c  = '0;
        src_c   = '0;
        fmt_c   = '0;
        data_d  = '0;
        frame_d = '0;
        base_d  = base_q;
        hold_d  = hold_q;

        for (int k = 0; k < int'(SAMPLES_PER_CHANNEL); k++) begin
            ramp_c[k*DATA_WIDTH +: DATA_WIDTH] = base_q + DATA_WIDTH'(k);
        end

        case (sel_c)
            SRC_DMA:  src_c = accept ? ddata : '0;
            SRC_ZERO: src_c = '0;
            SRC_RAMP: src_c = ramp_c;
            SRC_HOLD: src_c = hold_q;
            default:  src_c = '0;
        endcase

        if (!enable) begin
            src_c = '0;
        end

        // Offset binary: flip the sign bit of every lane after source selection.
        fmt_c = src_c;
        if (datafmt) begin
            for (int k = 0; k < int'(SAMPLES_PER_CHANNEL); k++) begin
                fmt_c[k*DATA_WIDTH + DATA_WIDTH - 1] = ~src_c[k*DATA_WIDTH + DATA_WIDTH - 1];
            end
        end

        if (run_active) begin
            data_d = fmt_c;
            if (enable && frame_mark) begin
                frame_d[0] = 1'b1;
            end
        end

        if (arm_entry) begin
            base_d = '0;
        end else if (run_active && enable && sel_c == SRC_RAMP) begin
            base_d = base_q + DATA_WIDTH'(SAMPLES_PER_CHANNEL);
        end

        if (enable && sel_c == SRC_DMA && accept) begin
            hold_d = ddata;
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            data_q  <= '0;
            frame_q <= '0;
            base_q  <= '0;
            hold_q  <= '0;
        end else begin
            data_q  <= data_d;
            frame_q <= frame_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/ad_dac_framer.sv
// DAC framer top: run FSM, frame counter, underflow tracking and channel array.
module ad_dac_framer
    import ad_dac_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS        = 2,
    parameter int unsigned SAMPLES_PER_CHANNEL = 4,
    parameter int unsigned DATA_WIDTH          = 16
) (
    input  logic                                                  dac_clk,
    input  logic                                                  dac_rstn,
    input  logic                                                  dac_run,
    input  logic                                                  dac_sync,
    input  logic [PERIOD_W-1:0]                                   dac_frame_period,
    input  logic                                                  dac_datafmt,
    input  logic [NUM_CHANNELS-1:0]                               dac_enable,
    input  logic [2*NUM_CHANNELS-1:0]                             dac_sel,
    input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH-1:0] dac_ddata,
    input  logic                                                  dac_dvalid,
    output logic                                                  dac_valid,
    output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH-1:0] dac_data,
    output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL-1:0]            dac_frame,
    output logic                                                  dac_dunf,
    output logic [UNF_W-1:0]                                      dac_unf_count,
    input  logic                                                  dac_unf_clr
);

    localparam int unsigned LANE_W = SAMPLES_PER_CHANNEL * DATA_WIDTH;

    dac_state_e          state_q, state_d;
    logic                valid_q, valid_d;
    logic                dunf_q, dunf_d;
    logic [UNF_W-1:0]    unf_count_q, unf_count_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cur_period_c;
    logic                dma_req_c, arm_entry_c, run_active_c, frame_mark_c, accept_c;

    assign run_active_c  = (state_q == ST_RUN);
    assign accept_c      = valid_q & dac_dvalid;
    assign dac_valid     = valid_q;
    assign dac_dunf      = dunf_q;
    assign dac_unf_count = unf_count_q;

    // Run FSM and DMA request; dropping dac_run returns to IDLE from any state.
    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        dma_req_c   = 1'b0;
        arm_entry_c = 1'b0;

        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            if (dac_enable[c] && src_sel_e'(dac_sel[2*c +: 2]) == SRC_DMA) begin
                dma_req_c = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: if (dac_sync) state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (!dac_run) begin
            state_d = ST_IDLE;
        end

        arm_entry_c = (state_q == ST_IDLE) && (state_d == ST_ARM);
        valid_d     = (state_d != ST_IDLE) && dma_req_c;
    end

    // Frame counter; the period is captured only at the start of each frame.
    always_comb begin
        cnt_d        = '0;
        period_d     = period_q;
        cur_period_c = period_q;
        frame_mark_c = 1'b0;

        if (run_active_c) begin
            if (cnt_q == '0) begin
                cur_period_c = eff_period(dac_frame_period);
                period_d     = cur_period_c;
                frame_mark_c = 1'b1;
            end
            if (cnt_q >= cur_period_c - PERIOD_W'(1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    // Underflow pulse and saturating counter; clear wins over increment.
    always_comb begin
        dunf_d      = run_active_c && valid_q && !dac_dvalid;
        unf_count_d = unf_count_q;
        if (dac_unf_clr) begin
            unf_count_d = '0;
        end else if (dunf_d && unf_count_q != '1) begin
            unf_count_d = unf_count_q + UNF_W'(1);
        end
    end

    // Control-path registers.
    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            dunf_q      <= 1'b0;
            unf_count_q <= '0;
            cnt_q       <= '0;
            period_q    <= PERIOD_W'(1);
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dunf_q      <= dunf_d;
            unf_count_q <= unf_count_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
        end
    end

    // One datapath slice per channel.
    for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
        ad_dac_framer_channel #(
            .SAMPLES_PER_CHANNEL(SAMPLES_PER_CHANNEL),
            .DATA_WIDTH         (DATA_WIDTH)
        ) u_ch (
            .dac_clk   (dac_clk),
            .dac_rstn  (dac_rstn),
            .run_active(run_active_c),
            .arm_entry (arm_entry_c),
            .frame_mark(frame_mark_c),
            .accept    (accept_c),
            .datafmt   (dac_datafmt),
            .enable    (dac_enable[c]),
            .sel       (dac_sel[2*c +: 2]),
            .ddata     (dac_ddata[c*LANE_W +: LANE_W]),
            .data      (dac_data[c*LANE_W +: LANE_W]),
            .frame     (dac_frame[c*SAMPLES_PER_CHANNEL +: SAMPLES_PER_CHANNEL])
        );
    end

endmodule

// File: tb/tb_ad_dac_framer.sv
// Scoreboard bench for ad_dac_framer with the default 2x4x16 configuration.
module tb_ad_dac_framer;

    localparam int DW_T = 128;

    logic            clk = 1'b0;
    logic            rstn;
    logic            run, sync, fmt, dvalid, clr;
    logic [7:0]      period;
    logic [1:0]      en;
    logic [3:0]      sel;
    logic [DW_T-1:0] ddata;
    logic            valid, dunf;
    logic [DW_T-1:0] data;
    logic [7:0]      frame;
    logic [15:0]     unf_count;

    ad_dac_framer #(.NUM_CHANNELS(2), .SAMPLES_PER_CHANNEL(4), .DATA_WIDTH(16)) dut (
        .dac_clk         (clk),
        .dac_rstn        (rstn),
        .dac_run         (run),
        .dac_sync        (sync),
        .dac_frame_period(period),
        .dac_datafmt     (fmt),
        .dac_enable      (en),
        .dac_sel         (sel),
        .dac_ddata       (ddata),
        .dac_dvalid      (dvalid),
        .dac_valid       (valid),
        .dac_data        (data),
        .dac_frame       (frame),
        .dac_dunf        (dunf),
        .dac_unf_count   (unf_count),
        .dac_unf_clr     (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        int              tnum;
        int              idx;
        logic [DW_T-1:0] data;
        logic [7:0]      frame;
        logic            valid;
        logic            dunf;
        logic [15:0]     cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare against the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m_e = sb.pop_front();
            checks = checks + 1;
            if (m_e.due != cyc || data !== m_e.data || frame !== m_e.frame ||
                valid !== m_e.valid || dunf !== m_e.dunf || unf_count !== m_e.cnt) begin
                errors = errors + 1;
                $display("FAIL t%0d.%0d: got data=%h frame=%h valid=%b dunf=%b cnt=%0d; need data=%h frame=%h valid=%b dunf=%b cnt=%0d (due %0d at %0d)",
                         m_e.tnum, m_e.idx, data, frame, valid, dunf, unf_count,
                         m_e.data, m_e.frame, m_e.valid, m_e.dunf, m_e.cnt, m_e.due, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int t, input int i, input int ofs, input logic [DW_T-1:0] d,
                            input logic [7:0] f, input logic v, input logic u, input logic [15:0] c);
        exp_t e;
        e.due = cyc + ofs; e.tnum = t; e.idx = i;
        e.data = d; e.frame = f; e.valid = v; e.dunf = u; e.cnt = c;
        sb.push_back(e);
    endtask

    // Expect the given outputs after the coming edge, then take that edge.
    task automatic rc(input int t, input int i, input logic [DW_T-1:0] d, input logic [7:0] f,
                      input logic v, input logic u);
        push_exp(t, i, 1, d, f, v, u, exp_cnt);
        tick();
    endtask

    function automatic logic [DW_T-1:0] dma_word(input int i);
        logic [DW_T-1:0] w;
        for (int l = 0; l < 8; l++) w[l*16 +: 16] = 16'(i*256 + l*17 + 3);
        return w;
    endfunction

    function automatic logic [DW_T-1:0] fill(input logic [15:0] s);
        logic [DW_T-1:0] w;
        for (int l = 0; l < 8; l++) w[l*16 +: 16] = s;
        return w;
    endfunction

    function automatic logic [DW_T-1:0] ramp_word(input int base);
        logic [DW_T-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[64 + k*16 +: 16] = 16'(base + k);
        return w;
    endfunction

    function automatic logic [DW_T-1:0] mix(input logic [DW_T-1:0] a, input logic [DW_T-1:0] b);
        logic [DW_T-1:0] w;
        w = a;
        w[127:64] = b[127:64];
        return w;
    endfunction

    function automatic logic [7:0] fr(input int i, input logic [7:0] m);
        return (i % 8 == 0) ? m : 8'h00;
    endfunction

    // From IDLE: one idle cycle, sync into ARM, then ARM into RUN.
    task automatic start_run(input int t, input logic v_exp);
        run = 1'b1; sync = 1'b0;
        push_exp(t, -3, 1, '0, 8'h00, 1'b0, 1'b0, exp_cnt); tick();
        sync = 1'b1;
        push_exp(t, -2, 1, '0, 8'h00, v_exp, 1'b0, exp_cnt); tick();
        sync = 1'b0;
        push_exp(t, -1, 1, '0, 8'h00, v_exp, 1'b0, exp_cnt); tick();
    endtask

    task automatic stop_run();
        run = 1'b0; dvalid = 1'b1;
        tick();
    endtask

    initial begin
        rstn = 1'b0; run = 1'b0; sync = 1'b0; fmt = 1'b0; dvalid = 1'b0; clr = 1'b0;
        period = 8'd8; en = 2'b11; sel = 4'b0000; ddata = '0;
        repeat (2) tick();
        push_exp(0, 0, 0, '0, 8'h00, 1'b0, 1'b0, 16'd0);
        tick();
        rstn = 1'b1;

        // Both channels DMA, constant dvalid; sync mid-RUN is ignored.
        dvalid = 1'b1;
        start_run(1, 1'b1);
        for (int i = 0; i <= 16; i++) begin
            ddata = dma_word(i);
            sync = (i == 5);
            rc(1, i, dma_word(i), fr(i, 8'h11), 1'b1, 1'b0);
        end
        sync = 1'b0;

        // Underflow burst, clear racing an underflow, then hold-last on channel 1.
        for (int i = 17; i <= 19; i++) begin
            dvalid = 1'b0; ddata = dma_word(i);
            exp_cnt = exp_cnt + 16'd1;
            rc(2, i, '0, 8'h00, 1'b1, 1'b1);
        end
        dvalid = 1'b1; ddata = dma_word(20);
        rc(2, 20, dma_word(20), 8'h00, 1'b1, 1'b0);
        dvalid = 1'b0; clr = 1'b1; ddata = dma_word(21); exp_cnt = 16'd0;
        rc(2, 21, '0, 8'h00, 1'b1, 1'b1);
        dvalid = 1'b1; clr = 1'b0; ddata = dma_word(22);
        rc(2, 22, dma_word(22), 8'h00, 1'b1, 1'b0);
        sel = 4'b1100; ddata = dma_word(23);
        rc(2, 23, mix(dma_word(23), dma_word(22)), 8'h00, 1'b1, 1'b0);
        ddata = dma_word(24);
        rc(2, 24, mix(dma_word(24), dma_word(22)), 8'h11, 1'b1, 1'b0);
        stop_run();

        // Channel 0 zero, channel 1 ramp, including the 16-bit wrap.
        sel = 4'b1001; dvalid = 1'b0; ddata = '0;
        start_run(3, 1'b0);
        for (int i = 0; i <= 16384; i++) begin
            if (i < 2 || i >= 16383) rc(3, i, ramp_word(4*i), fr(i, 8'h11), 1'b0, 1'b0);
            else tick();
        end
        stop_run();

        // Offset binary in zero mode, then channel 1 disabled.
        fmt = 1'b1; sel = 4'b0101; dvalid = 1'b0;
        start_run(4, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            if (i == 9) en = 2'b01;
            rc(4, i, fill(16'h8000), fr(i, (i >= 9) ? 8'h01 : 8'h11), 1'b0, 1'b0);
        end
        stop_run();
        fmt = 1'b0; en = 2'b11;

        // Period 8 -> 3 mid-frame, then 3 -> 0 (behaves as 1).
        period = 8'd8; dvalid = 1'b0;
        start_run(5, 1'b0);
        for (int i = 0; i <= 21; i++) begin
            logic [7:0] ef;
            if (i == 3) period = 8'd3;
            if (i == 15) period = 8'd0;
            ef = (i == 0 || (i >= 8 && i < 17 && (i - 8) % 3 == 0) || i >= 17) ? 8'h11 : 8'h00;
            rc(5, i, '0, ef, 1'b0, 1'b0);
        end
        stop_run();
        period = 8'd8;

        // Reset pulse mid-RUN: immediate zeros, then IDLE until a fresh sync.
        sel = 4'b0000; dvalid = 1'b1;
        start_run(6, 1'b1);
        for (int i = 0; i <= 2; i++) begin
            ddata = dma_word(i);
            rc(6, i, dma_word(i), fr(i, 8'h11), 1'b1, 1'b0);
        end
        ddata = dma_word(3);
        tick();
        rstn = 1'b0; exp_cnt = 16'd0;
        push_exp(6, 100, 0, '0, 8'h00, 1'b0, 1'b0, 16'd0);
        tick();
        rstn = 1'b1;
        for (int j = 0; j < 4; j++) rc(6, 200 + j, '0, 8'h00, 1'b0, 1'b0);
        sync = 1'b1;
        rc(6, 210, '0, 8'h00, 1'b1, 1'b0);
        sync = 1'b0;
        rc(6, 211, '0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i <= 2; i++) begin
            ddata = dma_word(50 + i);
            rc(6, 300 + i, dma_word(50 + i), fr(i, 8'h11), 1'b1, 1'b0);
        end

        repeat (3) tick();
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ad_dac_framer.md
AD_DAC_FRAMER -- requirements
Module: ad_dac_framer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, number of DAC channels (legal range 1..8).
REQ-002 SHALL have parameter SAMPLES_PER_CHANNEL, default 4, parallel samples per channel per clock (legal range 1..8).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, sample width in bits (legal range 8..16).
REQ-004 SHALL have the port dac_clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have the port dac_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have the port dac_run, input, 1 bit: level; high arms the framer and low stops it.
REQ-007 SHALL have the port dac_sync, input, 1 bit: single-cycle start pulse.
REQ-008 SHALL have the port dac_frame_period, input, 8 bits: frame length in cycles; value 0 is treated as 1.
REQ-009 SHALL have the port dac_datafmt, input, 1 bit: 1 selects offset-binary output (MSB of each sample inverted).
REQ-010 SHALL have the port dac_enable, input, NUM_CHANNELS bits: per-channel enable.
REQ-011 SHALL have the port dac_sel, input, 2*NUM_CHANNELS bits: per-channel source; 0 DMA, 1 zero, 2 ramp, 3 hold-last.
REQ-012 SHALL have the port dac_ddata, input, NUM_CHANNELS*SAMPLES_PER_CHANNEL*DATA_WIDTH bits: DMA data, channel-major and sample 0 in the LSBs.
REQ-013 SHALL have the port dac_dvalid, input, 1 bit: DMA data valid.
REQ-014 SHALL have the port dac_valid, output, 1 bit: DMA request.
REQ-015 SHALL have the port dac_data, output, same width as dac_ddata: formatted samples.
REQ-016 SHALL have the port dac_frame, output, NUM_CHANNELS*SAMPLES_PER_CHANNEL bits: per-lane frame marker.
REQ-017 SHALL have the port dac_dunf, output, 1 bit: single-cycle underflow flag.
REQ-018 SHALL have the port dac_unf_count, output, 16 bits: saturating underflow counter.
REQ-019 SHALL have the port dac_unf_clr, input, 1 bit: clears dac_unf_count.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, ARM and RUN.
REQ-021 SHALL move IDLE->ARM when dac_run=1 and dac_sync=1 in the same cycle, ARM->RUN unconditionally after one cycle, and any state->IDLE on the cycle following dac_run=0.
REQ-022 SHALL assert dac_valid only in ARM and RUN, and only if at least one enabled channel has dac_sel=0.
REQ-023 SHALL register dac_data and dac_frame with one cycle of latency from dac_ddata/dac_dvalid; no combinational path from input to output is permitted.
REQ-024 SHALL, in DMA mode, output dac_ddata when dac_valid=1 and dac_dvalid=1, and output zeros otherwise.
REQ-025 SHALL, in DMA mode, update a per-channel hold register only on accepted data.
REQ-026 SHALL, in zero mode, output all-zero samples.
REQ-027 SHALL, in ramp mode, output base+k on lane k, then advance base by SAMPLES_PER_CHANNEL each RUN cycle, with wrap modulo 2^DATA_WIDTH; base SHALL be cleared on entry to ARM.
REQ-028 SHALL, in hold-last mode, repeat that channel's hold register every cycle.
REQ-029 SHALL output zeros on a disabled channel regardless of dac_sel, and SHALL keep that channel's ramp and hold state frozen.
REQ-030 SHALL output zeros on every channel while in IDLE or ARM.
REQ-031 SHALL apply dac_datafmt after source selection, inverting the sample MSB, so an offset-binary zero reads 0x8000 at DATA_WIDTH=16.
REQ-032 SHALL run a frame counter from 0 to period-1, wrapping in RUN and cleared in IDLE and ARM.
REQ-033 SHALL set dac_frame lane 0 of each enabled channel high on the output word produced at count 0, and hold all other lanes low.
REQ-034 SHALL sample dac_frame_period only at count 0, so a mid-frame change takes effect at the next frame.
REQ-035 SHALL pulse dac_dunf for one cycle when in RUN with dac_valid=1 and dac_dvalid=0.
REQ-036 SHALL increment dac_unf_count on each dac_dunf pulse and saturate it at 0xFFFF.
REQ-037 SHALL give dac_unf_clr priority over a simultaneous increment, so the count becomes 0.
REQ-038 SHALL ignore dac_sync while in ARM or RUN.

Reset
REQ-039 SHALL, while dac_rstn=0, immediately force: FSM to IDLE, dac_valid 0, dac_data 0, dac_frame 0, dac_dunf 0, dac_unf_count 0, frame counter 0, ramp bases 0, and hold registers 0.
REQ-040 SHALL, on reset assertion mid-RUN, return to IDLE and require a fresh dac_sync with dac_run=1 to restart.

Structure
REQ-041 SHALL take the source-select encodings (DMA/ZERO/RAMP/HOLD) and FSM state encodings from a shared package, ad_dac_pkg.
REQ-042 SHALL place per-channel source muxing, ramp, hold and format logic in one sub-module, ad_dac_framer_channel, instantiated NUM_CHANNELS times.
REQ-043 SHALL keep the FSM, frame counter and underflow logic in the top level.

Verification
REQ-044 SHALL cover: NUM_CHANNELS=2, SAMPLES_PER_CHANNEL=4, both channels DMA, run plus sync, constant dvalid and ddata ramp -> data one cycle delayed, frame every 8 cycles with period=8.
REQ-045 SHALL cover: dvalid low for 3 RUN cycles -> 3 dac_dunf pulses, zeros output, count=3; clr asserted alongside a fourth underflow -> count=0.
REQ-046 SHALL cover: channel 1 in ramp mode at DATA_WIDTH=16 -> lanes 0,1,2,3 then 4..7, and wrap at 0xFFFC -> 0xFFFC..0xFFFF then 0..3.
REQ-047 SHALL cover: datafmt=1 in zero mode -> every sample reads 0x8000; channel disabled -> 0x8000 with no frame marker.
REQ-048 SHALL cover: period changed from 8 to 3 mid-frame -> current frame completes 8 cycles, then frames of 3.
REQ-049 SHALL cover: dac_rstn pulsed low mid-RUN -> outputs 0 immediately and stay in IDLE until a new sync arrives.
